// File: rtl/axi4_bram_slave_if.sv
// AXI4-full slave-side bus bundle for axi4_bram_slave (AW/W/B write and AR/R read channels).
interface axi4_bram_slave_if #(
  parameter int unsigned ID_W   = 1,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ID_W-1:0]   S_AXI_AWID;
  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic [7:0]        S_AXI_AWLEN;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [DATA_W-1:0] S_AXI_WDATA;
  logic [STRB_W-1:0] S_AXI_WSTRB;
  logic              S_AXI_WLAST;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [ID_W-1:0]   S_AXI_BID;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [ID_W-1:0]   S_AXI_ARID;
  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic [7:0]        S_AXI_ARLEN;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [ID_W-1:0]   S_AXI_RID;
  logic [DATA_W-1:0] S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RLAST;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi4_bram_slave.sv
// AXI4-full INCR-burst slave on a dual-port word RAM; independent write and read engines.
// Optional AXI_SLV_RANGE_CHK_EN flags bursts running past the end of memory with SLVERR.
module axi4_bram_slave #(
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_MEM_DEPTH        = 4096
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESET,
  axi4_bram_slave_if.slave  s_axi
);
  localparam int unsigned STRB_W   = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned WORD_W   = $clog2(C_MEM_DEPTH);
  localparam int unsigned SUM_W    = WORD_W + 9;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

  w_state_e                    w_state_q, w_state_d;
  logic [WORD_W-1:0]           w_word_q, w_word_d;
  logic [7:0]                  w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic                        w_err_q, w_err_d, w_oor_q, w_oor_d;
  logic [C_S_AXI_ID_WIDTH-1:0] bid_q, bid_d;
  logic [1:0]                  bresp_q, bresp_d;
  logic                        awready_q, wready_q, bvalid_q;
  logic                        w_mem_we_c;

  r_state_e                    r_state_q, r_state_d;
  logic [WORD_W-1:0]           r_word_q, r_word_d;
  logic [7:0]                  r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic                        r_oor_q, r_oor_d;
  logic [C_S_AXI_ID_WIDTH-1:0] rid_q, rid_d;
  logic [1:0]                  rresp_q, rresp_d;
  logic                        rlast_q, rlast_d;
  logic                        arready_q, rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic                        ram_en_c;
  logic [WORD_W-1:0]           ram_addr_c;

  logic [WORD_W-1:0] aw_word_c, ar_word_c;
  logic              aw_oor_c, ar_oor_c;
  logic              unused_c;

  assign aw_word_c = s_axi.S_AXI_AWADDR[ADDR_LSB +: WORD_W];
  assign ar_word_c = s_axi.S_AXI_ARADDR[ADDR_LSB +: WORD_W];
  assign unused_c  = ^{s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR};

`ifdef AXI_SLV_RANGE_CHK_EN
  assign aw_oor_c = (SUM_W'(aw_word_c) + SUM_W'(s_axi.S_AXI_AWLEN)) >= SUM_W'(C_MEM_DEPTH);
  assign ar_oor_c = (SUM_W'(ar_word_c) + SUM_W'(s_axi.S_AXI_ARLEN)) >= SUM_W'(C_MEM_DEPTH);
`else
  assign aw_oor_c = 1'b0;
  assign ar_oor_c = 1'b0;
`endif

  // Write engine next state: WLAST is only checked, the beat counter ends the burst.
  always_comb begin
    w_state_d  = w_state_q;
    w_word_d   = w_word_q;
    w_len_d    = w_len_q;
    w_cnt_d    = w_cnt_q;
    w_err_d    = w_err_q;
    w_oor_d    = w_oor_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    w_mem_we_c = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (s_axi.S_AXI_AWVALID && awready_q) begin
          w_word_d  = aw_word_c;
          w_len_d   = s_axi.S_AXI_AWLEN;
          w_cnt_d   = 8'd0;
          w_oor_d   = aw_oor_c;
          w_err_d   = aw_oor_c;
          bid_d     = s_axi.S_AXI_AWID;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi.S_AXI_WVALID && wready_q) begin
          w_mem_we_c = !w_oor_q;
          w_word_d   = w_word_q + WORD_W'(1);
          w_cnt_d    = w_cnt_q + 8'd1;
          if (s_axi.S_AXI_WLAST != (w_cnt_q == w_len_q)) w_err_d = 1'b1;
          if (w_cnt_q == w_len_q) begin
            w_state_d = W_RESP;
            bresp_d   = w_err_d ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY && bvalid_q) begin
          w_state_d = W_IDLE;
          bresp_d   = RESP_OKAY;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      w_state_q <= W_IDLE;
      w_word_q  <= '0;
      w_len_q   <= 8'd0;
      w_cnt_q   <= 8'd0;
      w_err_q   <= 1'b0;
      w_oor_q   <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_word_q  <= w_word_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      w_oor_q   <= w_oor_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      awready_q <= (w_state_d == W_IDLE);
      wready_q  <= (w_state_d == W_DATA);
      bvalid_q  <= (w_state_d == W_RESP);
    end
  end

  // Byte-enabled write port; contents survive reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_mem_we_c) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (s_axi.S_AXI_WSTRB[b]) mem[w_word_q][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // Read engine next state: RAM is read ahead on fetch and on every accepted beat.
  always_comb begin
    r_state_d  = r_state_q;
    r_word_d   = r_word_q;
    r_len_d    = r_len_q;
    r_cnt_d    = r_cnt_q;
    r_oor_d    = r_oor_q;
    rid_d      = rid_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    ram_en_c   = 1'b0;
    ram_addr_c = r_word_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (s_axi.S_AXI_ARVALID && arready_q) begin
          r_word_d  = ar_word_c;
          r_len_d   = s_axi.S_AXI_ARLEN;
          r_cnt_d   = 8'd0;
          r_oor_d   = ar_oor_c;
          rid_d     = s_axi.S_AXI_ARID;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        ram_en_c  = 1'b1;
        r_state_d = R_DATA;
        rlast_d   = (r_len_q == 8'd0);
        rresp_d   = r_oor_q ? RESP_SLVERR : RESP_OKAY;
      end
      R_DATA: begin
        if (rvalid_q && s_axi.S_AXI_RREADY) begin
          ram_en_c   = 1'b1;
          ram_addr_c = r_word_q + WORD_W'(1);
          r_word_d   = r_word_q + WORD_W'(1);
          r_cnt_d    = r_cnt_q + 8'd1;
          if (r_cnt_q == r_len_q) begin
            r_state_d = R_IDLE;
            rlast_d   = 1'b0;
            rresp_d   = RESP_OKAY;
          end else begin
            rlast_d   = (r_cnt_d == r_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_state_q <= R_IDLE;
      r_word_q  <= '0;
      r_len_q   <= 8'd0;
      r_cnt_q   <= 8'd0;
      r_oor_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_word_q  <= r_word_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_oor_q   <= r_oor_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      arready_q <= (r_state_d == R_IDLE);
      rvalid_q  <= (r_state_d == R_DATA);
    end
  end

  // RAM output register; only advances on fetch/accept so a stalled beat holds.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rdata_q <= '0;
    end else if (ram_en_c) begin
      rdata_q <= r_oor_q ? '0 : mem[ram_addr_c];
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BID     = bid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RID     = rid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RLAST   = rlast_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
endmodule

// File: tb/tb_axi4_bram_slave.sv
// Directed bench for axi4_bram_slave: burst write/read, strobes, stalls, WLAST error, reset, range/wrap.
module tb_axi4_bram_slave;
  logic S_AXI_ACLK;
  logic S_AXI_ARESET;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] model [4096];

  axi4_bram_slave_if #(.ID_W(1), .ADDR_W(32), .DATA_W(32)) bus ();

  axi4_bram_slave #(
    .C_S_AXI_ID_WIDTH(1), .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32), .C_MEM_DEPTH(4096)
  ) dut (
    .S_AXI_ACLK(S_AXI_ACLK),
    .S_AXI_ARESET(S_AXI_ARESET),
    .s_axi(bus)
  );

  initial S_AXI_ACLK = 1'b0;
  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] raddr;
    logic [31:0] pre;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge S_AXI_ACLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input logic [3:0] strb,
                          input logic [31:0] base, input int last_beat, input logic [1:0] exp_bresp,
                          input bit upd, input int bhold);
    logic [11:0] word;
    logic [11:0] idx;
    logic [31:0] d;
    logic        idv;
    bit          got;
    int          n;
    word = addr[13:2];
    idv  = 1'(len);
    bus.S_AXI_AWID = idv; bus.S_AXI_AWADDR = addr; bus.S_AXI_AWLEN = 8'(len);
    bus.S_AXI_AWVALID = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin got = bus.S_AXI_AWREADY; tick(); end
    bus.S_AXI_AWVALID = 1'b0;
    chk("aw_accept", 64'(got), 64'd1);
    n = 0;
    for (int b = 0; b <= len; b++) begin
      d = base + 32'(b);
      bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = strb; bus.S_AXI_WLAST = (b == last_beat);
      bus.S_AXI_WVALID = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin got = bus.S_AXI_WREADY; tick(); end
      if (got) n++;
      if (upd) begin
        idx = word + 12'(b);
        for (int k = 0; k < 4; k++) if (strb[k]) model[idx][8*k +: 8] = d[8*k +: 8];
      end
    end
    bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
    chk("w_beats", 64'(n), 64'(len + 1));
    chk("w_ready_drop", 64'(bus.S_AXI_WREADY), 64'd0);
    for (int i = 0; i < 50 && !bus.S_AXI_BVALID; i++) tick();
    for (int i = 0; i < bhold; i++) begin
      chk("b_hold_valid", 64'(bus.S_AXI_BVALID), 64'd1);
      chk("b_hold_awready", 64'(bus.S_AXI_AWREADY), 64'd0);
      tick();
    end
    chk("bvalid", 64'(bus.S_AXI_BVALID), 64'd1);
    chk("bresp", 64'(bus.S_AXI_BRESP), 64'(exp_bresp));
    chk("bid", 64'(bus.S_AXI_BID), 64'(idv));
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    chk("b_done", 64'(bus.S_AXI_BVALID), 64'd0);
    chk("aw_ready_after_b", 64'(bus.S_AXI_AWREADY), 64'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] exp_resp,
                         input bit toggle, input bit zero, output logic [31:0] first_d);
    logic [11:0] word;
    logic [11:0] idx;
    logic [31:0] hold_d;
    logic [31:0] exp;
    logic        hold_l;
    logic        idv;
    bit          got;
    bit          stalled;
    int          beat;
    word = addr[13:2];
    idv  = ~1'(len);
    first_d = 32'h0;
    hold_d = 32'h0; hold_l = 1'b0;
    bus.S_AXI_ARID = idv; bus.S_AXI_ARADDR = addr; bus.S_AXI_ARLEN = 8'(len);
    bus.S_AXI_ARVALID = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin got = bus.S_AXI_ARREADY; tick(); end
    bus.S_AXI_ARVALID = 1'b0;
    chk("ar_accept", 64'(got), 64'd1);
    chk("r_lat_t1", 64'(bus.S_AXI_RVALID), 64'd0);
    tick();
    chk("r_lat_t2", 64'(bus.S_AXI_RVALID), 64'd1);
    beat = 0; stalled = 1'b0;
    for (int c = 0; c < 4 * (len + 1) + 20 && beat <= len; c++) begin
      bus.S_AXI_RREADY = !(toggle && (c % 2 == 1));
      if (bus.S_AXI_RVALID) begin
        if (stalled) begin
          chk("r_stable_data", 64'(bus.S_AXI_RDATA), 64'(hold_d));
          chk("r_stable_last", 64'(bus.S_AXI_RLAST), 64'(hold_l));
        end
        if (bus.S_AXI_RREADY) begin
          idx = word + 12'(beat);
          exp = zero ? 32'h0 : model[idx];
          if (beat == 0) first_d = bus.S_AXI_RDATA;
          chk("rdata", 64'(bus.S_AXI_RDATA), 64'(exp));
          chk("rlast", 64'(bus.S_AXI_RLAST), 64'(beat == len));
          chk("rresp", 64'(bus.S_AXI_RRESP), 64'(exp_resp));
          chk("rid", 64'(bus.S_AXI_RID), 64'(idv));
          beat++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hold_d = bus.S_AXI_RDATA;
          hold_l = bus.S_AXI_RLAST;
        end
      end
      tick();
    end
    bus.S_AXI_RREADY = 1'b0;
    chk("r_beats", 64'(beat), 64'(len + 1));
    chk("r_done", 64'(bus.S_AXI_RVALID), 64'd0);
  endtask

  vec_t        vecs [6];
  logic [31:0] rd;
  int          nb;

  initial begin
    vecs[0] = '{waddr: 32'h0000_0100, raddr: 32'h0000_0100, pre: 32'hAABB_CCDD, data: 32'h1122_3344, strb: 4'b0011, exp: 32'hAABB_3344};
    vecs[1] = '{waddr: 32'h0000_0204, raddr: 32'h0000_0204, pre: 32'h0000_0000, data: 32'hDEAD_BEEF, strb: 4'b1111, exp: 32'hDEAD_BEEF};
    vecs[2] = '{waddr: 32'h0000_020B, raddr: 32'h0000_0208, pre: 32'h1234_5678, data: 32'h9ABC_DEF0, strb: 4'b1100, exp: 32'h9ABC_5678};
    vecs[3] = '{waddr: 32'h0000_0300, raddr: 32'h0000_0300, pre: 32'hFFFF_FFFF, data: 32'h0000_0000, strb: 4'b0000, exp: 32'hFFFF_FFFF};
    vecs[4] = '{waddr: 32'h0000_3FFC, raddr: 32'h0000_3FFC, pre: 32'h0000_0000, data: 32'h55AA_55AA, strb: 4'b1001, exp: 32'h5500_00AA};
    vecs[5] = '{waddr: 32'h0000_4000, raddr: 32'h0000_0000, pre: 32'h0102_0304, data: 32'hA0B0_C0D0, strb: 4'b0110, exp: 32'h01B0_C004};

    S_AXI_ARESET = 1'b1;
    bus.S_AXI_AWID = '0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARID = '0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_awready", 64'(bus.S_AXI_AWREADY), 64'd0);
    chk("rst_wready",  64'(bus.S_AXI_WREADY),  64'd0);
    chk("rst_bvalid",  64'(bus.S_AXI_BVALID),  64'd0);
    chk("rst_bresp",   64'(bus.S_AXI_BRESP),   64'd0);
    chk("rst_bid",     64'(bus.S_AXI_BID),     64'd0);
    chk("rst_arready", 64'(bus.S_AXI_ARREADY), 64'd0);
    chk("rst_rvalid",  64'(bus.S_AXI_RVALID),  64'd0);
    chk("rst_rdata",   64'(bus.S_AXI_RDATA),   64'd0);
    chk("rst_rlast",   64'(bus.S_AXI_RLAST),   64'd0);
    chk("rst_rresp",   64'(bus.S_AXI_RRESP),   64'd0);
    chk("rst_rid",     64'(bus.S_AXI_RID),     64'd0);
    S_AXI_ARESET = 1'b0;
    tick();
    chk("idle_awready", 64'(bus.S_AXI_AWREADY), 64'd1);
    chk("idle_arready", 64'(bus.S_AXI_ARREADY), 64'd1);

    // 64-beat burst, readback, then stalled readback
    do_write(32'h100, 63, 4'hF, 32'h0, 63, 2'b00, 1'b1, 0);
    do_read(32'h100, 63, 2'b00, 1'b0, 1'b0, rd);
    chk("burst_first", 64'(rd), 64'd0);
    do_read(32'h100, 15, 2'b00, 1'b1, 1'b0, rd);

    // Response backpressure, then early WLAST
    do_write(32'h800, 1, 4'hF, 32'hC0DE_0000, 1, 2'b00, 1'b1, 5);
    do_write(32'h900, 7, 4'hF, 32'h0000_0500, 3, 2'b10, 1'b1, 0);
    do_read(32'h900, 7, 2'b00, 1'b0, 1'b0, rd);
    chk("early_wlast_first", 64'(rd), 64'h500);

    // Single-word strobe table
    for (int v = 0; v < 6; v++) begin
      do_write(vecs[v].waddr, 0, 4'hF, vecs[v].pre, 0, 2'b00, 1'b1, 0);
      do_write(vecs[v].waddr, 0, vecs[v].strb, vecs[v].data, 0, 2'b00, 1'b1, 0);
      do_read(vecs[v].raddr, 0, 2'b00, 1'b0, 1'b0, rd);
      chk($sformatf("tbl%0d_rdata", v), 64'(rd), 64'(vecs[v].exp));
    end

    // Reset mid read burst: 5 beats taken, then async reset
    bus.S_AXI_ARID = 1'b0; bus.S_AXI_ARADDR = 32'h180; bus.S_AXI_ARLEN = 8'd31;
    bus.S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 50 && !bus.S_AXI_ARREADY; i++) tick();
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b1;
    nb = 0;
    for (int c = 0; c < 60 && nb < 5; c++) begin
      if (bus.S_AXI_RVALID) nb++;
      tick();
    end
    bus.S_AXI_RREADY = 1'b0;
    chk("mid_beats", 64'(nb), 64'd5);
    chk("mid_rvalid", 64'(bus.S_AXI_RVALID), 64'd1);
    chk("mid_rdata", 64'(bus.S_AXI_RDATA), 64'd37);
    S_AXI_ARESET = 1'b1;
    #1;
    chk("async_rvalid", 64'(bus.S_AXI_RVALID), 64'd0);
    chk("async_rdata", 64'(bus.S_AXI_RDATA), 64'd0);
    chk("async_arready", 64'(bus.S_AXI_ARREADY), 64'd0);
    @(posedge S_AXI_ACLK);
    #1;
    S_AXI_ARESET = 1'b0;
    tick();
    chk("post_rst_arready", 64'(bus.S_AXI_ARREADY), 64'd1);
    do_read(32'h180, 3, 2'b00, 1'b0, 1'b0, rd);
    chk("post_rst_first", 64'(rd), 64'd32);

`ifdef AXI_SLV_RANGE_CHK_EN
    // Boundary: last in-range burst is fine, one beat further is SLVERR
    do_write(32'h3FF8, 1, 4'hF, 32'h77, 1, 2'b00, 1'b1, 0);
    do_read(32'h3FF8, 1, 2'b00, 1'b0, 1'b0, rd);
    chk("edge_first", 64'(rd), 64'h77);
    do_write(32'h3FF8, 3, 4'hF, 32'h99, 3, 2'b10, 1'b0, 0);
    do_read(32'h3FF8, 3, 2'b10, 1'b0, 1'b1, rd);
    do_read(32'h3FF8, 1, 2'b00, 1'b0, 1'b0, rd);
    chk("oor_no_write", 64'(rd), 64'h77);
`else
    // Wrap from the top of memory back to word 0
    do_write(32'h3FF8, 3, 4'hF, 32'h77, 3, 2'b00, 1'b1, 0);
    do_read(32'h3FF8, 3, 2'b00, 1'b0, 1'b0, rd);
    chk("wrap_first", 64'(rd), 64'h77);
    do_read(32'h0, 0, 2'b00, 1'b0, 1'b0, rd);
    chk("wrap_word0", 64'(rd), 64'h79);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
